// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state codes and flag bit indices for alu_multicycle
package alu_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_ADD  = 4'd0;
    localparam op_t OP_SUB  = 4'd1;
    localparam op_t OP_AND  = 4'd2;
    localparam op_t OP_OR   = 4'd3;
    localparam op_t OP_SHR  = 4'd4;
    localparam op_t OP_SHRA = 4'd5;
    localparam op_t OP_SHL  = 4'd6;
    localparam op_t OP_ROR  = 4'd7;
    localparam op_t OP_ROL  = 4'd8;
    localparam op_t OP_NEG  = 4'd9;
    localparam op_t OP_NOT  = 4'd10;
    localparam op_t OP_MUL  = 4'd11;
    localparam op_t OP_DIV  = 4'd12;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_MUL  = 3'd1;
    localparam state_t ST_DIV  = 3'd2;
    localparam state_t ST_FIX  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - radix-2 Booth multiply and restoring divide iteration datapath
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start_mul,
    input  logic             start_div,
    input  logic             step_mul,
    input  logic             step_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] mul_hi,
    output logic [WIDTH-1:0] mul_lo,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    localparam int SHW = $clog2(WIDTH);

    // acc is one bit wider so Booth never overflows with a most-negative multiplicand
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   mcand;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   acc_n;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             q_m1;
    logic             neg_q;
    logic             neg_r;
    logic [SHW-1:0]   cnt;

    always_comb begin
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
        endcase
        acc_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        q_n   = {booth_sum[0], q[WIDTH-1:1]};
    end

    assign shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
    assign diff    = shifted - mcand;
    assign a_mag   = a[WIDTH-1] ? -a : a;
    assign b_mag   = b[WIDTH-1] ? -b : b;

    // mul outputs are the post-step value so the top can latch on the final step edge
    assign mul_hi = acc_n[WIDTH-1:0];
    assign mul_lo = q_n;
    assign last   = &cnt;
    assign quo    = neg_q ? -q : q;
    assign rem    = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            acc   <= '0;
            mcand <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            cnt   <= '0;
        end else if (start_mul) begin
            acc   <= '0;
            mcand <= {a[WIDTH-1], a};
            q     <= b;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else if (start_div) begin
            acc   <= '0;
            mcand <= {1'b0, b_mag};
            q     <= a_mag;
            q_m1  <= 1'b0;
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r <= a[WIDTH-1];
            cnt   <= '0;
        end else if (step_mul) begin
            acc  <= acc_n;
            q    <= q_n;
            q_m1 <= q[0];
            cnt  <= cnt + 1'b1;
        end else if (step_div) begin
            acc <= diff[WIDTH] ? shifted : diff;
            q   <= {q[WIDTH-2:0], ~diff[WIDTH]};
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - clocked ALU with multi-cycle MUL/DIV; optional ALU_FLAGS_EN adds flags
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] zhi,
    output logic [WIDTH-1:0] zlo,
`ifdef ALU_FLAGS_EN
    output logic [3:0]       flags,
`endif
    output logic             div_by_zero
);

    localparam int SHW = $clog2(WIDTH);

    state_t             state;
    logic               accept;
    logic               is_mul;
    logic               is_div;
    logic               div_zero;
    logic               b_big;
    logic               last;
    logic               load_res;
    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] rot_r;
    logic [2*WIDTH-1:0] rot_l;
    logic [WIDTH-1:0]   sc_lo;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   mul_hi;
    logic [WIDTH-1:0]   mul_lo;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // DONE accepts a new op so results can stream back-to-back
    assign accept   = start && (state == ST_IDLE || state == ST_DONE);
    assign is_mul   = (op == OP_MUL);
    assign is_div   = (op == OP_DIV);
    assign div_zero = is_div && (b == '0);
    assign b_big    = |b[WIDTH-1:SHW];
    assign sh       = b[SHW-1:0];
    assign rot_r    = {a, a} >> sh;
    assign rot_l    = {a, a} << sh;
    assign busy     = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
    assign done     = (state == ST_DONE);

    always_comb begin
        sc_lo = '0;
        case (op)
            OP_ADD:  sc_lo = a + b;
            OP_SUB:  sc_lo = a - b;
            OP_AND:  sc_lo = a & b;
            OP_OR:   sc_lo = a | b;
            OP_SHR:  sc_lo = b_big ? '0 : a >> sh;
            OP_SHRA: sc_lo = b_big ? {WIDTH{a[WIDTH-1]}} : $signed(a) >>> sh;
            OP_SHL:  sc_lo = b_big ? '0 : a << sh;
            OP_ROR:  sc_lo = rot_r[WIDTH-1:0];
            OP_ROL:  sc_lo = rot_l[2*WIDTH-1:WIDTH];
            OP_NEG:  sc_lo = -b;
            OP_NOT:  sc_lo = ~b;
            OP_DIV:  sc_lo = '1;
            default: sc_lo = '0;
        endcase
    end

    always_comb begin
        load_res = 1'b0;
        res_hi   = '0;
        res_lo   = sc_lo;
        if (accept && !is_mul && !(is_div && !div_zero)) begin
            load_res = 1'b1;
            res_hi   = div_zero ? a : '0;
        end else if (state == ST_MUL && last) begin
            load_res = 1'b1;
            res_hi   = mul_hi;
            res_lo   = mul_lo;
        end else if (state == ST_FIX) begin
            load_res = 1'b1;
            res_hi   = rem;
            res_lo   = quo;
        end
    end

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_seq (
        .clock     (clock),
        .clear     (clear),
        .start_mul (accept && is_mul),
        .start_div (accept && is_div && !div_zero),
        .step_mul  (state == ST_MUL),
        .step_div  (state == ST_DIV),
        .a         (a),
        .b         (b),
        .last      (last),
        .mul_hi    (mul_hi),
        .mul_lo    (mul_lo),
        .quo       (quo),
        .rem       (rem)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= ST_IDLE;
            zhi         <= '0;
            zlo         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (load_res) begin
                zhi <= res_hi;
                zlo <= res_lo;
            end
            if (accept) begin
                div_by_zero <= div_zero;
                if (is_mul)
                    state <= ST_MUL;
                else if (is_div && !div_zero)
                    state <= ST_DIV;
                else
                    state <= ST_DONE;
            end else begin
                case (state)
                    ST_MUL:  if (last) state <= ST_DONE;
                    ST_DIV:  if (last) state <= ST_FIX;
                    ST_FIX:  state <= ST_DONE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef ALU_FLAGS_EN
    op_t              op_r;
    op_t              res_op;
    logic [3:0]       flags_d;
    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   sub_x;

    assign add_x  = {1'b0, a} + {1'b0, b};
    assign sub_x  = {1'b0, a} - {1'b0, b};
    assign res_op = accept ? op : op_r;

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = res_lo[WIDTH-1];
        flags_d[FLAG_Z] = (res_op == OP_MUL) ? ({res_hi, res_lo} == '0) : (res_lo == '0);
        case (res_op)
            OP_ADD: begin
                flags_d[FLAG_C] = add_x[WIDTH];
                flags_d[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (add_x[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                flags_d[FLAG_C] = sub_x[WIDTH];
                flags_d[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (sub_x[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NEG:  flags_d[FLAG_V] = (b == {1'b1, {(WIDTH-1){1'b0}}});
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            op_r  <= '0;
            flags <= '0;
        end else begin
            if (accept)
                op_r <= op;
            if (load_res)
                flags <= flags_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle with a behavioural reference model
module tb_alu_multicycle;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
    } exp_t;

    logic        clock;
    logic        clear;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] zhi;
    logic [31:0] zlo;
    logic        div_by_zero;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .zhi         (zhi),
        .zlo         (zlo),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int t);
        exp_t   e;
        longint sx;
        longint sy;
        longint p;
        int     r;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        e.hi  = 32'd0;
        e.lo  = 32'd0;
        e.dbz = 1'b0;
        e.due = t + 1;
        r     = int'(y % 32);
        case (o)
            4'd0:  e.lo = x + y;
            4'd1:  e.lo = x - y;
            4'd2:  e.lo = x & y;
            4'd3:  e.lo = x | y;
            4'd4:  e.lo = (y >= 32) ? 32'd0 : x >> y;
            4'd5:  e.lo = (y >= 32) ? (x[31] ? 32'hFFFF_FFFF : 32'd0) : $signed(x) >>> y;
            4'd6:  e.lo = (y >= 32) ? 32'd0 : x << y;
            4'd7:  e.lo = (r == 0) ? x : ((x >> r) | (x << (32 - r)));
            4'd8:  e.lo = (r == 0) ? x : ((x << r) | (x >> (32 - r)));
            4'd9:  e.lo = 32'd0 - y;
            4'd10: e.lo = ~y;
            4'd11: begin
                p     = sx * sy;
                e.hi  = p[63:32];
                e.lo  = p[31:0];
                e.due = t + 33;
            end
            4'd12: begin
                if (y == 32'd0) begin
                    e.lo  = 32'hFFFF_FFFF;
                    e.hi  = x;
                    e.dbz = 1'b1;
                end else begin
                    p     = sx / sy;
                    e.lo  = p[31:0];
                    p     = sx % sy;
                    e.hi  = p[31:0];
                    e.due = t + 34;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        exp_t e;
        if (!clear && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("zlo", {32'd0, zlo}, {32'd0, e.lo});
                chk("zhi", {32'd0, zhi}, {32'd0, e.hi});
                chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
                chk("latency", 64'(cyc), 64'(e.due));
                chk("busy_at_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            chk("issue_timeout", {63'd0, busy}, 64'd0);
        end else begin
            start = 1'b1;
            op    = o;
            a     = x;
            b     = y;
            sb.push_back(model(o, x, y, cyc));
            @(negedge clock);
            start = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!done)
            chk("done_timeout", {63'd0, done}, 64'd1);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'($signed($urandom_range(0, 40)) - 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        int          n;

        clear = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(negedge clock);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_zhi", {32'd0, zhi}, 64'd0);
        chk("reset_zlo", {32'd0, zlo}, 64'd0);
        chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        clear = 1'b0;
        @(negedge clock);

        issue(4'd0, 32'h7FFF_FFFF, 32'd1);
        issue(4'd11, 32'hFFFF_FFFD, 32'd5);
        chk("mul_busy", {63'd0, busy}, 64'd1);
        issue(4'd12, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        issue(4'd12, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(4'd12, 32'h0000_1234, 32'd0);
        issue(4'd0, 32'd3, 32'd4);
        issue(4'd7, 32'h8000_0001, 32'd33);
        issue(4'd6, 32'd1, 32'd32);
        issue(4'd5, 32'h8000_0000, 32'd40);

        // MUL with a start pulse that must be ignored, then an abort by clear
        issue(4'd11, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (4) @(negedge clock);
        start = 1'b1;
        op    = 4'd0;
        a     = 32'd1;
        b     = 32'd1;
        @(negedge clock);
        start = 1'b0;
        chk("ignored_start_busy", {63'd0, busy}, 64'd1);
        repeat (4) @(negedge clock);
        #3 clear = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_zhi", {32'd0, zhi}, 64'd0);
        chk("abort_zlo", {32'd0, zlo}, 64'd0);
        sb.delete();
        @(negedge clock);
        clear = 1'b0;
        issue(4'd0, 32'd2, 32'd3);

        issue(4'd11, 32'h4000_0000, 32'h8000_0000);
        issue(4'd11, 32'h8000_0000, 32'h8000_0000);
        issue(4'd12, 32'd7, 32'hFFFF_FFFE);
        issue(4'd12, 32'hFFFF_FFF9, 32'hFFFF_FFFE);

        for (int i = 0; i < 200; i++) begin
            o = 4'($urandom_range(0, 15));
            x = rnd_operand();
            y = rnd_operand();
            if (o >= 4'd4 && o <= 4'd8 && $urandom_range(0, 1) == 1)
                y = $urandom_range(0, 40);
            if (o == 4'd12 && $urandom_range(0, 9) == 0)
                y = 32'd0;
            issue(o, x, y);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
